// File: rtl/accum_pkg.sv
// accum_pkg: shared FSM state type and seven-segment encodings for accumulator_n
package accum_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} accum_state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Active-low gfedcba patterns, indexed by nibble value (entry 0 is the rightmost element).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/accumulator_n_hex_driver.sv
// hex_driver: one active-low seven-segment digit from a nibble, or blank
//   nibble : 4-bit value to display
//   blank  : 1 forces all segments off
//   seg    : active-low segments {g,f,e,d,c,b,a}
module hex_driver
    import accum_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb seg = blank ? SEG_BLANK : HEX_SEG[nibble];
endmodule

// File: rtl/accumulator_n.sv
// accumulator_n: pushbutton-driven add/subtract accumulator with LED and hex display
//   Clk, Reset_Clear (sync, active-high), Run_Accumulate (async button), Mode (0 add, 1 sub)
//   SW operand in; LED = acc[DATA_W-1:0]; Ovf sticky overflow; HEX0..HEX5 active-low digits
//   Define ACCUMULATOR_SATURATE_EN to clamp on overflow/underflow instead of wrapping.
module accumulator_n
    import accum_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_Clear,
    input  logic              Run_Accumulate,
    input  logic              Mode,
    input  logic [DATA_W-1:0] SW,
    output logic [DATA_W-1:0] LED,
    output logic              Ovf,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);
    logic [1:0]       sync_q;
    logic             run_s;
    accum_state_t     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sw_x, res;
    logic             ovf_q, ovf_d, carry;
    logic [ACC_W:0]   sum, diff;
    logic [23:0]      acc24;
    logic [6:0]       hex_w [6];

    assign run_s = sync_q[1];
    assign sw_x  = ACC_W'(SW);
    assign sum   = {1'b0, acc_q} + {1'b0, sw_x};
    assign diff  = {1'b0, acc_q} - {1'b0, sw_x};

    always_comb begin
        state_d = (state_q == IDLE && run_s)  ? ACCUM :
                  (state_q == ACCUM)          ? HOLD  :
                  (state_q == HOLD && !run_s) ? IDLE  : state_q;
        carry = Mode ? diff[ACC_W] : sum[ACC_W];
`ifdef ACCUMULATOR_SATURATE_EN
        res = carry ? (Mode ? '0 : '1) : (Mode ? diff[ACC_W-1:0] : sum[ACC_W-1:0]);
`else
        res = Mode ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
`endif
        acc_d = (state_q == ACCUM) ? res : acc_q;
        ovf_d = ovf_q | (state_q == ACCUM && carry);
    end

    always_ff @(posedge Clk) sync_q <= {sync_q[0], Run_Accumulate};

    // Reset lands in HOLD so a button held through reset must be released first.
    always_ff @(posedge Clk) begin
        if (Reset_Clear) begin
            state_q <= HOLD;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign LED   = acc_q[DATA_W-1:0];
    assign Ovf   = ovf_q;
    assign acc24 = 24'(acc_q);

    for (genvar i = 0; i < 6; i++) begin : g_hex
        hex_driver u_hex (
            .nibble(acc24[4*i +: 4]),
            .blank (i >= (ACC_W + 3) / 4),
            .seg   (hex_w[i])
        );
    end

    assign HEX0 = hex_w[0];
    assign HEX1 = hex_w[1];
    assign HEX2 = hex_w[2];
    assign HEX3 = hex_w[3];
    assign HEX4 = hex_w[4];
    assign HEX5 = hex_w[5];
endmodule

// File: tb/tb_accumulator_n.sv
// tb_accumulator_n: directed scoreboard bench for accumulator_n (DATA_W=10, ACC_W=16)
module tb_accumulator_n;
    import accum_pkg::*;

    typedef struct {
        logic [15:0] acc;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, run, mode;
    logic [9:0] sw;
    logic [9:0] led;
    logic       ovf;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] model_acc = '0;
    logic        model_ovf = 1'b0;
    exp_t        exp_q[$];

    accumulator_n #(.DATA_W(10), .ACC_W(16)) dut (
        .Clk(clk), .Reset_Clear(rst), .Run_Accumulate(run), .Mode(mode), .SW(sw),
        .LED(led), .Ovf(ovf),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] acc, input logic o);
        logic [6:0] hx [6];
        hx[0] = hex0; hx[1] = hex1; hx[2] = hex2; hx[3] = hex3; hx[4] = hex4; hx[5] = hex5;
        check({tag, "_led"}, 32'(led), 32'(acc[9:0]));
        check({tag, "_ovf"}, 32'(ovf), 32'(o));
        for (int d = 0; d < 6; d++)
            check($sformatf("%s_hex%0d", tag, d), 32'(hx[d]), 32'(d < 4 ? seg(acc[4*d +: 4]) : 7'h7F));
    endtask

    task automatic apply(input logic [9:0] s, input logic m);
        int t;
        t = m ? int'(model_acc) - int'(s) : int'(model_acc) + int'(s);
        if (t > 65535 || t < 0) begin
            model_ovf = 1'b1;
`ifdef ACCUMULATOR_SATURATE_EN
            t = (t < 0) ? 0 : 65535;
`else
            t = t & 32'hFFFF;
`endif
        end
        model_acc = t[15:0];
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_acc = '0;
        model_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Press: value must be unchanged after 3 edges and updated after the 4th.
    task automatic press(input logic [9:0] s, input logic m, input int hold);
        exp_t e;
        logic [15:0] pa;
        logic po;
        @(negedge clk); sw = s; mode = m; run = 1'b1;
        pa = model_acc; po = model_ovf;
        apply(s, m);
        e.acc = model_acc; e.ovf = model_ovf;
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("pre_update", pa, po);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check_all("update", e.acc, e.ovf);
        repeat (hold) @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        check_all("released", model_acc, model_ovf);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mode = 1'b0; sw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all("reset", 16'h0000, 1'b0);

        for (int k = 0; k < 4; k++) press(10'h033, 1'b0, 0);
        check("four_presses_led", 32'(led), 32'h0CC);
        check("four_presses_hex1", 32'(hex1), 32'h46);

        do_reset();
        press(10'h033, 1'b0, 100);
        check("long_hold_led", 32'(led), 32'h033);
        press(10'h033, 1'b0, 0);
        check("repress_led", 32'(led), 32'h066);

        do_reset();
        for (int k = 0; k < 64; k++) press(10'h3FF, 1'b0, 0);
        press(10'h030, 1'b0, 0);
        check("pre_wrap_ovf", 32'(ovf), 32'h0);
        press(10'h3FF, 1'b0, 0);
        check("add_ovf", 32'(ovf), 32'h1);
`ifdef ACCUMULATOR_SATURATE_EN
        check("add_sat_led", 32'(led), 32'h3FF);
`else
        check("add_wrap_led", 32'(led), 32'h3EF);
`endif

        do_reset();
        press(10'h010, 1'b0, 0);
        press(10'h020, 1'b1, 0);
        check("sub_ovf", 32'(ovf), 32'h1);
`ifdef ACCUMULATOR_SATURATE_EN
        check("sub_sat_led", 32'(led), 32'h000);
`else
        check("sub_wrap_led", 32'(led), 32'h3F0);
`endif

        do_reset();
        @(negedge clk); sw = 10'h007; mode = 1'b0; run = 1'b1;
        repeat (6) @(negedge clk);
        check_all("held_before_reset", 16'h0007, 1'b0);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_all("reset_in_hold", 16'h0000, 1'b0);
        repeat (20) @(negedge clk);
        check_all("held_after_reset", 16'h0000, 1'b0);
        run = 1'b0;
        repeat (4) @(negedge clk);
        model_acc = '0; model_ovf = 1'b0;
        press(10'h005, 1'b0, 0);
        check("repress_after_reset", 32'(led), 32'h005);

        @(negedge clk); sw = 10'h009; mode = 1'b0; run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_all("reset_vs_accum", 16'h0000, 1'b0);
        check("reset_vs_accum_state", 32'(dut.state_q), 32'(HOLD));
        repeat (10) @(negedge clk);
        check_all("reset_vs_accum_held", 16'h0000, 1'b0);
        run = 1'b0;
        repeat (4) @(negedge clk);
        model_acc = '0; model_ovf = 1'b0;
        press(10'h2AB, 1'b0, 0);
        check("final_led", 32'(led), 32'h2AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
